mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the RV32I pipeline, placed directly downstream of the execute stage. It consumes the registered execute result (ALU sum as effective address, or plain result), store data and control. It runs the data-memory request/response handshake, performs byte-lane alignment and load sign/zero extension, and produces the writeback-bound result. It stalls upstream while a memory access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 16: cycles allowed in one handshake phase before the access is aborted (must be ≥2).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_valid`  in  1  an instruction is presented from execute.
- `i_alu_result`  in  32  execute result; this is the effective address for memory operations.
- `i_store_data`  in  32  rs2 value for stores.
- `i_mem_read` / `i_mem_write`  in  1 each  load / store operation.
- `i_funct3`  in  3  access size and sign selection.
- `i_rd`  in  5  destination register.
- `i_reg_write`  in  1  instruction writes rd.
- `o_dmem_req`  out  1  memory request.
- `o_dmem_we`  out  1  request is a write.
- `o_dmem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `o_dmem_wdata`  out  32  lane-replicated store data.
- `o_dmem_be`  out  4  byte enables; 0 for reads.
- `i_dmem_ready`  in  1  memory accepts the request this cycle.
- `i_dmem_rvalid`  in  1  read data valid.
- `i_dmem_rdata`  in  32  read word.
- `o_stall`  out  1  hold the upstream stage.
- `o_wb_valid`  out  1  one-cycle pulse; the result fields below are valid.
- `o_wb_data`  out  32  writeback value.
- `o_wb_rd`  out  5  destination register.
- `o_wb_reg_write`  out  1  write enable; forced 0 on any fault.
- `o_addr_fault`  out  1  pulse with `o_wb_valid`: misaligned access or illegal encoding.
- `o_bus_error`  out  1  pulse with `o_wb_valid`: handshake timeout.

## Operation
- FSM states are IDLE, REQ and WAIT. `o_stall = (state != IDLE)`.
- Inputs are sampled only in IDLE when `i_valid` is high. The op, address, data and rd are latched on accept.
- **Non-memory op** (neither read nor write): register `i_alu_result`, rd and reg_write, then pulse `o_wb_valid` next cycle. State stays IDLE.
- **Fault** (checked in IDLE): any of the following causes no request. Instead, pulse `o_wb_valid` and `o_addr_fault` next cycle with `o_wb_reg_write=0`, and stay in IDLE.
  - read and write both set;
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- **Valid memory op**: go to REQ. In REQ, `o_dmem_req=1` and the address, we, wdata and be are held stable until `i_dmem_ready`.
  - Store on ready: go to IDLE and pulse `o_wb_valid` next cycle with `o_wb_reg_write=0`.
  - Load on ready: go to WAIT. On `i_dmem_rvalid`, register the extracted value, go to IDLE, and pulse `o_wb_valid` next cycle.
- **Store lanes**:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{d[15:0]}}`.
  - SW: `be = 4'b1111`.
- **Load extract**: select byte `rdata[8*addr[1:0]+:8]` or halfword `rdata[16*addr[1]+:16]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- **Timeout**: the phase counter clears on entry to REQ and on the REQ→WAIT transition.
  - After `TIMEOUT_CYCLES` cycles in a phase with no completion, drop `o_dmem_req` and go to IDLE.
  - Next cycle, pulse `o_wb_valid` and `o_bus_error` with `o_wb_reg_write=0`.
- `i_dmem_rvalid` outside WAIT is ignored. `i_dmem_ready` outside REQ is ignored.

## Timing
- **Reset**: state is IDLE and the counter is 0. Every output is 0, including `o_stall`, `o_dmem_req`, `o_wb_valid`, `o_wb_data` and `o_dmem_addr`.
- **Reset mid-access**: `o_dmem_req` drops on the first reset edge. No `o_wb_valid` is produced for the aborted op.
- **Latencies**, with accept at cycle N:
  - Non-memory op or fault: `o_wb_valid` at N+1.
  - Zero-wait store: REQ at N+1 with ready, `o_wb_valid` at N+2.
  - Zero-wait load: REQ at N+1, rvalid at N+2, `o_wb_valid` at N+3.
- `o_stall` is high exactly during the REQ and WAIT cycles. The next instruction is accepted in the IDLE cycle that follows, which is also the cycle in which `o_wb_valid` of the previous op is high.
- Memory returns `i_dmem_rvalid` no earlier than the cycle after `i_dmem_ready`.
- Back-to-back non-memory ops give one `o_wb_valid` per cycle, with no stall.

## Test plan
- **ALU passthrough**: `i_valid=1`, no mem, result `0xDEADBEEF`, rd=5 → next cycle `o_wb_valid=1`, `o_wb_data=0xDEADBEEF`, `o_wb_rd=5`, `o_stall=0` throughout.
- **SB to address 0x1003**, data `0x000000A5`, ready on the first REQ cycle → `o_dmem_addr=0x1000`, `be=1000`, `wdata=0xA5A5A5A5`, `we=1`, stall for 1 cycle, `o_wb_valid` with `reg_write=0`.
- **LB/LBU/LH from 0x2002**, rdata `0x80F17F00`:
  - LB gives `0xFFFFFFF1`;
  - LBU gives `0x000000F1`;
  - LH gives `0xFFFF80F1`.
- **Ready held low for 3 cycles on an LW** → req, addr and be stable for 4 cycles, stall for 5 cycles with rvalid immediate, then correct data.
- **LW at 0x3002 and SH at 0x3001** → no `o_dmem_req`, `o_addr_fault` and `o_wb_valid` next cycle, `reg_write=0`.
- **Load with rvalid never asserted** (`TIMEOUT_CYCLES=4`) → `o_dmem_req` drops, `o_bus_error` pulses. Assert `i_rst` during a separate WAIT → outputs are 0 the next cycle, and a late rvalid is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit for the RV32I pipeline.
// Accepts one instruction at a time from execute. It drives the data-memory
// request/response handshake and aligns store lanes and load data. It also
// produces a single-cycle writeback pulse per instruction. Upstream is stalled
// while a memory access is in flight.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_write,
    output logic        o_addr_fault,
    output logic        o_bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Fields of the accepted instruction that are needed after the request phase.
    logic [2:0]       funct3_p0;
    logic [1:0]       offs_p0;
    logic [4:0]       rd_p0;
    logic             reg_write_p0;

    // Misaligned access, both read and write set, or a funct3 the op does not define.
    function automatic logic access_fault(input logic       rd_op,
                                          input logic       wr_op,
                                          input logic [2:0] f3,
                                          input logic [1:0] offs);
        logic bad;
        bad = 1'b0;
        if (rd_op && wr_op)
            bad = 1'b1;
        else if (f3[1:0] == 2'b11)
            bad = 1'b1;
        else if (rd_op && f3 == 3'b110)
            bad = 1'b1;
        else if (wr_op && f3[2])
            bad = 1'b1;
        else if (f3[1:0] == 2'b01 && offs[0])
            bad = 1'b1;
        else if (f3[1:0] == 2'b10 && offs != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << offs;
            2'b01:   be = offs[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enables alone pick the target bytes.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Select the addressed byte/halfword from the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  offs);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{offs, 3'b000} +: 8];
        h = rdata[{offs[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign o_stall = (state != IDLE);

    // Control FSM: accept in IDLE, hold the request in REQ, collect read data in WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            funct3_p0      <= '0;
            offs_p0        <= '0;
            rd_p0          <= '0;
            reg_write_p0   <= 1'b0;
            o_dmem_req     <= 1'b0;
            o_dmem_we      <= 1'b0;
            o_dmem_addr    <= '0;
            o_dmem_wdata   <= '0;
            o_dmem_be      <= '0;
            o_wb_valid     <= 1'b0;
            o_wb_data      <= '0;
            o_wb_rd        <= '0;
            o_wb_reg_write <= 1'b0;
            o_addr_fault   <= 1'b0;
            o_bus_error    <= 1'b0;
        end else begin
            o_wb_valid   <= 1'b0;
            o_addr_fault <= 1'b0;
            o_bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        funct3_p0    <= i_funct3;
                        offs_p0      <= i_alu_result[1:0];
                        rd_p0        <= i_rd;
                        reg_write_p0 <= i_reg_write;
                        if (!i_mem_read && !i_mem_write) begin
                            o_wb_valid     <= 1'b1;
                            o_wb_data      <= i_alu_result;
                            o_wb_rd        <= i_rd;
                            o_wb_reg_write <= i_reg_write;
                        end else if (access_fault(i_mem_read, i_mem_write, i_funct3,
                                                  i_alu_result[1:0])) begin
                            o_wb_valid     <= 1'b1;
                            o_addr_fault   <= 1'b1;
                            o_wb_data      <= '0;
                            o_wb_rd        <= i_rd;
                            o_wb_reg_write <= 1'b0;
                        end else begin
                            state        <= REQ;
                            cnt          <= '0;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_mem_write;
                            o_dmem_addr  <= {i_alu_result[31:2], 2'b00};
                            o_dmem_be    <= i_mem_write ?
                                            store_be(i_funct3[1:0], i_alu_result[1:0]) : 4'b0000;
                            o_dmem_wdata <= i_mem_write ?
                                            store_wdata(i_funct3[1:0], i_store_data) : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_ready) begin
                        o_dmem_req <= 1'b0;
                        cnt        <= '0;
                        if (o_dmem_we) begin
                            state          <= IDLE;
                            o_wb_valid     <= 1'b1;
                            o_wb_data      <= '0;
                            o_wb_rd        <= rd_p0;
                            o_wb_reg_write <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state          <= IDLE;
                        o_dmem_req     <= 1'b0;
                        o_wb_valid     <= 1'b1;
                        o_bus_error    <= 1'b1;
                        o_wb_data      <= '0;
                        o_wb_rd        <= rd_p0;
                        o_wb_reg_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        state          <= IDLE;
                        o_wb_valid     <= 1'b1;
                        o_wb_data      <= load_extract(i_dmem_rdata, funct3_p0, offs_p0);
                        o_wb_rd        <= rd_p0;
                        o_wb_reg_write <= reg_write_p0;
                    end else if (cnt == CNT_LAST) begin
                        state          <= IDLE;
                        o_wb_valid     <= 1'b1;
                        o_bus_error    <= 1'b1;
                        o_wb_data      <= '0;
                        o_wb_rd        <= rd_p0;
                        o_wb_reg_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues instructions and queues
// the expected memory request and writeback; a memory responder and a writeback
// monitor pop and compare independently.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_store_data = '0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [4:0]  i_rd = '0;
    logic        i_reg_write = 1'b0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ready = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_stall;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic        o_addr_fault;
    logic        o_bus_error;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_funct3       (i_funct3),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_be      (o_dmem_be),
        .i_dmem_ready   (i_dmem_ready),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall        (o_stall),
        .o_wb_valid     (o_wb_valid),
        .o_wb_data      (o_wb_data),
        .o_wb_rd        (o_wb_rd),
        .o_wb_reg_write (o_wb_reg_write),
        .o_addr_fault   (o_addr_fault),
        .o_bus_error    (o_bus_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        fault;
        logic        berr;
        logic        chk;
        int          stall;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    wb_t  exp_wb[$];
    req_t exp_req[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Memory responder behaviour for the instruction in flight.
    int          cfg_rdly = 0;
    int          cfg_vdly = 0;
    bit          cfg_no_ready = 1'b0;
    bit          cfg_no_rvalid = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          noise_mode = 0;  // 0 quiet, 1 random ready/rvalid when not expected, 2 rvalid forced high

    logic [2:0] ld_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort_run(input string name);
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
            return 1'b1;
        if (wr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1'b1;
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int          sz;
        int          sh;
        logic [31:0] v;
        logic [31:0] span;
        sz = size_of(f3);
        sh = int'(a[1:0]);
        if (sz == 4) return w;
        span = 32'h1 << (8 * sz);
        v = (w >> (8 * sh)) & (span - 32'h1);
        if (!f3[2] && v >= (span >> 1)) v = v - span;
        return v;
    endfunction

    function automatic logic [31:0] replicate(input int sz, input logic [31:0] d);
        if (sz == 1) return 32'(d[7:0]) * 32'h01010101;
        if (sz == 2) return 32'(d[15:0]) * 32'h00010001;
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] dst, input bit rw,
                         input int rdly, input int vdly, input bit no_rdy, input bit no_rv,
                         input logic [31:0] rdata);
        wb_t  e;
        req_t r;
        int   guard;
        int   sz;
        int   sh;
        guard = 0;
        while (o_stall) begin
            @(posedge i_clk);
            #1;
            guard++;
            if (guard > 64) abort_run("issue_wait_idle");
        end
        cfg_rdly      = rdly;
        cfg_vdly      = vdly;
        cfg_no_ready  = no_rdy;
        cfg_no_rvalid = no_rv;
        cfg_rdata     = rdata;
        i_valid      = 1'b1;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_funct3     = f3;
        i_alu_result = a;
        i_store_data = d;
        i_rd         = dst;
        i_reg_write  = rw;
        e.data = '0; e.rd = dst; e.rw = 1'b0; e.fault = 1'b0; e.berr = 1'b0; e.chk = 1'b0;
        e.stall = 0;
        if (!rd && !wr) begin
            e.data = a; e.rw = rw; e.chk = 1'b1;
        end else if (is_fault(rd, wr, f3, a)) begin
            e.fault = 1'b1;
        end else begin
            sz = size_of(f3);
            sh = int'(a[1:0]);
            r.we = wr;
            r.addr = a - 32'(sh);
            r.be = 4'b0000;
            r.wdata = '0;
            if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (k >= sh && k < sh + sz) r.be[k] = 1'b1;
                r.wdata = replicate(sz, d);
            end
            exp_req.push_back(r);
            if (no_rdy) begin
                e.berr = 1'b1; e.stall = TO;
            end else if (wr) begin
                e.stall = rdly + 1;
            end else if (no_rv) begin
                e.berr = 1'b1; e.stall = rdly + 1 + TO;
            end else begin
                e.stall = rdly + vdly + 2;
                e.data = load_val(f3, a, rdata);
                e.rw = rw;
                e.chk = 1'b1;
            end
        end
        exp_wb.push_back(e);
        @(posedge i_clk);
        #1;
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(o_stall), 32'd0);
        check({tag, "_dmem_req"}, 32'(o_dmem_req), 32'd0);
        check({tag, "_dmem_we"}, 32'(o_dmem_we), 32'd0);
        check({tag, "_dmem_addr"}, o_dmem_addr, 32'd0);
        check({tag, "_dmem_wdata"}, o_dmem_wdata, 32'd0);
        check({tag, "_dmem_be"}, 32'(o_dmem_be), 32'd0);
        check({tag, "_wb_valid"}, 32'(o_wb_valid), 32'd0);
        check({tag, "_wb_data"}, o_wb_data, 32'd0);
        check({tag, "_wb_rd"}, 32'(o_wb_rd), 32'd0);
        check({tag, "_wb_reg_write"}, 32'(o_wb_reg_write), 32'd0);
        check({tag, "_flags"}, 32'({o_addr_fault, o_bus_error}), 32'd0);
    endtask

    task automatic reset_mid(input bit in_wait);
        int guard;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd7, 1'b1, 0, 0, !in_wait, 1'b1, 32'd0);
        guard = 0;
        while (in_wait && !(o_stall && !o_dmem_req)) begin
            @(posedge i_clk);
            #1;
            guard++;
            if (guard > 16) abort_run("reach_wait");
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check_all_zero(in_wait ? "rst_in_wait" : "rst_in_req");
        exp_wb.delete();
        i_rst = 1'b0;
        noise_mode = 2;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            check("late_rvalid_wb", 32'(o_wb_valid), 32'd0);
            check("late_rvalid_stall", 32'(o_stall), 32'd0);
        end
        noise_mode = 0;
    endtask

    // ---------------- memory responder / request checker ----------------
    int   req_n = 0;
    int   wait_n = 0;
    req_t cur;
    always @(negedge i_clk) begin
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = $urandom;
        if (o_dmem_req) begin
            if (req_n == 0) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", 32'(o_dmem_req), 32'd0);
                end else begin
                    cur = exp_req.pop_front();
                    check("req_we", 32'(o_dmem_we), 32'(cur.we));
                    check("req_addr", o_dmem_addr, cur.addr);
                    check("req_be", 32'(o_dmem_be), 32'(cur.be));
                    if (cur.we) check("req_wdata", o_dmem_wdata, cur.wdata);
                end
            end else begin
                check("hold_addr", o_dmem_addr, cur.addr);
                check("hold_be", 32'(o_dmem_be), 32'(cur.be));
                check("hold_we", 32'(o_dmem_we), 32'(cur.we));
            end
            if (!cfg_no_ready && req_n >= cfg_rdly) i_dmem_ready = 1'b1;
            req_n++;
        end else begin
            req_n = 0;
            if (noise_mode == 1) i_dmem_ready = 1'($urandom);
        end
        if (o_stall && !o_dmem_req) begin
            if (!cfg_no_rvalid && wait_n >= cfg_vdly) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = cfg_rdata;
            end
            wait_n++;
        end else begin
            wait_n = 0;
            if (noise_mode == 1) i_dmem_rvalid = 1'($urandom);
            if (noise_mode == 2) i_dmem_rvalid = 1'b1;
        end
    end

    // ---------------- writeback monitor ----------------
    int  run = 0;
    wb_t got;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_stall) begin
                run++;
                check("wb_in_stall", 32'(o_wb_valid), 32'd0);
            end else begin
                if (o_wb_valid) begin
                    if (exp_wb.size() == 0) begin
                        check("unexpected_wb", 32'(o_wb_valid), 32'd0);
                    end else begin
                        got = exp_wb.pop_front();
                        check("wb_reg_write", 32'(o_wb_reg_write), 32'(got.rw));
                        check("wb_addr_fault", 32'(o_addr_fault), 32'(got.fault));
                        check("wb_bus_error", 32'(o_bus_error), 32'(got.berr));
                        check("stall_cycles", 32'(run), 32'(got.stall));
                        if (got.chk) begin
                            check("wb_data", o_wb_data, got.data);
                            check("wb_rd", 32'(o_wb_rd), 32'(got.rd));
                        end
                    end
                end else begin
                    check("stray_flags", 32'({o_addr_fault, o_bus_error}), 32'd0);
                end
                run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          kind;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          guard;

        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst = 1'b0;
        noise_mode = 0;

        // ALU passthrough, SB with lane replication, sub-word loads
        issue(1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd5, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, 5'd10, 1'b1, 0, 0, 1'b0, 1'b0, 32'h80F1_7F00);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'd0, 5'd11, 1'b1, 0, 0, 1'b0, 1'b0, 32'h80F1_7F00);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd12, 1'b1, 0, 0, 1'b0, 1'b0, 32'h80F1_7F00);
        // LW with ready held low for three cycles
        issue(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 5'd13, 1'b1, 3, 0, 1'b0, 1'b0, 32'h1234_5678);
        // misaligned word load and halfword store
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 5'd14, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_1234, 5'd15, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0);
        // timeouts in WAIT and in REQ
        issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd16, 1'b1, 0, 0, 1'b0, 1'b1, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 5'd17, 1'b0, 0, 0, 1'b1, 1'b0, 32'd0);
        // back-to-back non-memory ops
        for (int i = 0; i < 4; i++)
            issue(1'b0, 1'b0, 3'b000, 32'h1111_0000 + 32'(i), 32'd0, 5'(20 + i), 1'b1, 0, 0,
                  1'b0, 1'b0, 32'd0);
        reset_mid(1'b1);
        reset_mid(1'b0);

        noise_mode = 1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 2 && kind <= 5) || kind == 9;
            wr = (kind >= 6);
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (rd && !wr) f3 = ld_ok[$urandom_range(0, 4)];
                else if (wr && !rd) f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            issue(rd, wr, f3, a, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
        end

        guard = 0;
        while (exp_wb.size() != 0 && guard < 64) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        check("req_queue_drained", 32'(exp_req.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
